ising_core_ctrl: RTL and testbench

- Per-core job sequencer between a register-interface slave port of the SoC external register bus and one Ising core.
- Software programs an iteration count and issues START over the register interface.
- The block then issues the annealing iterations to the core one at a time with a valid/ready handshake and waits for each completion pulse.
- It reports status and raises a completion interrupt.

---
 rtl/ising_core_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_ising_core_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ising_core_ctrl.sv
// ising_core_ctrl: per-core job sequencer between the register bus and one Ising core.
// Software sets NUM_ITER and writes START. The block then hands the iterations to the
// core one at a time and waits for each done pulse. It reports BUSY/DONE/ABORTED and
// the progress count in STATUS, and raises a level interrupt.
//
// Optional build macro LAGD_ISING_CTRL_PERF_EN adds a read-only PERF_CYCLES counter at
// 0xC. Without the macro, 0xC is unmapped.
//
// Core handshake: an iteration transfers on a rising clock edge when core_iter_valid_o
// and core_iter_ready_i are both high. While valid is up, core_iter_idx_o holds steady
// and valid stays high until that edge (or until an abort that arrives without a
// handshake). After a transfer, the core returns one core_iter_done_i pulse.
module ising_core_ctrl #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IterWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [AddrWidth-1:0] reg_addr_i,
  input  logic [DataWidth-1:0] reg_wdata_i,
  input  logic [3:0]           reg_wstrb_i,
  output logic                 reg_ready_o,
  output logic [DataWidth-1:0] reg_rdata_o,
  output logic                 reg_error_o,
  output logic                 core_iter_valid_o,
  input  logic                 core_iter_ready_i,
  output logic [IterWidth-1:0] core_iter_idx_o,
  input  logic                 core_iter_done_i,
  output logic                 irq_o
);

  if (DataWidth != 32) begin : g_bad_data_width
    $error("ising_core_ctrl: DataWidth must be 32");
  end
  if (AddrWidth < 5) begin : g_bad_addr_width
    $error("ising_core_ctrl: AddrWidth must be at least 5");
  end
  if (IterWidth > 16 || IterWidth < 1) begin : g_bad_iter_width
    $error("ising_core_ctrl: IterWidth must be 1..16 to fit STATUS[31:16]");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t               state;
  logic [IterWidth-1:0] num_iter;
  logic [IterWidth-1:0] progress;
  logic [IterWidth-1:0] prog_inc;
  logic [15:0]          prog16;
  logic                 irq_en;
  logic                 done;
  logic                 aborted;
  logic                 busy;

  logic                 addr_hi_zero;
  logic [1:0]           reg_idx;
  logic                 ctrl_we;
  logic                 num_we;
  logic                 stat_we;
  logic                 start_go;
  logic                 abort_go;

`ifdef LAGD_ISING_CTRL_PERF_EN
  logic [31:0]          perf_cnt;
`endif

  assign busy         = (state != IDLE);
  assign prog_inc     = progress + IterWidth'(1);
  assign prog16       = 16'(progress);
  assign addr_hi_zero = (reg_addr_i[AddrWidth-1:4] == '0);
  assign reg_idx      = reg_addr_i[3:2];
  assign reg_ready_o  = reg_valid_i;

  // A request that carries both START and ABORT is an abort. START can only be
  // accepted while IDLE, because a START write while busy is refused in decode.
  assign start_go = ctrl_we & reg_wdata_i[0] & ~reg_wdata_i[1];
  assign abort_go = ctrl_we & reg_wdata_i[1];

  assign core_iter_valid_o = (state == ISSUE);
  assign core_iter_idx_o   = progress;
  assign irq_o             = (done | aborted) & irq_en;

  // Register decode: read data, error flag and per-register write enables.
  // Any request that gets an error also gets no write enable.
  always_comb begin
    reg_rdata_o = '0;
    reg_error_o = 1'b0;
    ctrl_we     = 1'b0;
    num_we      = 1'b0;
    stat_we     = 1'b0;
    if (reg_valid_i) begin
      if (!addr_hi_zero) begin
        reg_error_o = 1'b1;
      end else begin
        case (reg_idx)
          2'd0: reg_rdata_o[2] = irq_en;
          2'd1: reg_rdata_o[IterWidth-1:0] = num_iter;
          2'd2: begin
            reg_rdata_o[0]     = busy;
            reg_rdata_o[1]     = done;
            reg_rdata_o[2]     = aborted;
            reg_rdata_o[31:16] = prog16;
          end
          default: begin
`ifdef LAGD_ISING_CTRL_PERF_EN
            reg_rdata_o = perf_cnt;
`else
            reg_error_o = 1'b1;
`endif
          end
        endcase
        if (reg_write_i && !reg_error_o) begin
          if (reg_wstrb_i != 4'hF) begin
            reg_error_o = 1'b1;
          end else begin
            case (reg_idx)
              2'd0: begin
                if (reg_wdata_i[0] && !reg_wdata_i[1] && busy) reg_error_o = 1'b1;
                else                                             ctrl_we     = 1'b1;
              end
              2'd1: begin
                if (busy) reg_error_o = 1'b1;
                else      num_we      = 1'b1;
              end
              2'd2:    stat_we     = 1'b1;
              default: reg_error_o = 1'b1;
            endcase
          end
        end
      end
    end
  end

  // Software-owned configuration: the IRQ enable and the iteration count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      irq_en   <= 1'b0;
      num_iter <= '0;
    end else begin
      if (ctrl_we) irq_en   <= reg_wdata_i[2];
      if (num_we)  num_iter <= reg_wdata_i[IterWidth-1:0];
    end
  end

  // Sequencer FSM. It owns progress and the DONE/ABORTED flags. The W1C clears
  // come first, so a set by the FSM in the same cycle wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      progress <= '0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      if (stat_we) begin
        if (reg_wdata_i[1]) done    <= 1'b0;
        if (reg_wdata_i[2]) aborted <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (start_go) begin
            progress <= '0;
            aborted  <= 1'b0;
            if (num_iter == '0) begin
              done <= 1'b1;
            end else begin
              done  <= 1'b0;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (abort_go) begin
            // An iteration accepted in the abort cycle must still be drained.
            if (core_iter_ready_i) begin
              state <= DRAIN;
            end else begin
              aborted <= 1'b1;
              state   <= IDLE;
            end
          end else if (core_iter_ready_i) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (core_iter_done_i) begin
            progress <= prog_inc;
            if (abort_go) begin
              // The outstanding iteration finished in the abort cycle: nothing to drain.
              aborted <= 1'b1;
              state   <= IDLE;
            end else if (prog_inc == num_iter) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= ISSUE;
            end
          end else if (abort_go) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (core_iter_done_i) begin
            progress <= prog_inc;
            aborted  <= 1'b1;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LAGD_ISING_CTRL_PERF_EN
  // Busy-cycle counter. It is cleared when a job starts and it saturates at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_cnt <= '0;
    end else if (start_go) begin
      perf_cnt <= '0;
    end else if (busy && perf_cnt != 32'hFFFF_FFFF) begin
      perf_cnt <= perf_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ising_core_ctrl.sv
// Directed testbench for ising_core_ctrl. A small core model answers handshakes and
// pulses done a set number of cycles after each transfer. It also logs the issued
// indices.
module tb_ising_core_ctrl;

  localparam logic [31:0] A_CTRL = 32'h0;
  localparam logic [31:0] A_NUM  = 32'h4;
  localparam logic [31:0] A_STAT = 32'h8;
  localparam logic [31:0] A_PERF = 32'hC;

  logic        clk;
  logic        rst;
  logic        reg_valid;
  logic        reg_write;
  logic [31:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ready;
  logic [31:0] reg_rdata;
  logic        reg_error;
  logic        core_valid;
  logic        core_ready;
  logic [15:0] core_idx;
  logic        core_done;
  logic        core_done_m;
  logic        spur_done;
  logic        irq;

  int          n_chk;
  int          n_fail;
  int          done_delay;
  logic [15:0] hs_q[$];
  logic [15:0] exp_q[$];

  assign core_done = core_done_m | spur_done;

  ising_core_ctrl #(.AddrWidth(32), .DataWidth(32), .IterWidth(16)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .reg_valid_i       (reg_valid),
    .reg_write_i       (reg_write),
    .reg_addr_i        (reg_addr),
    .reg_wdata_i       (reg_wdata),
    .reg_wstrb_i       (reg_wstrb),
    .reg_ready_o       (reg_ready),
    .reg_rdata_o       (reg_rdata),
    .reg_error_o       (reg_error),
    .core_iter_valid_o (core_valid),
    .core_iter_ready_i (core_ready),
    .core_iter_idx_o   (core_idx),
    .core_iter_done_i  (core_done),
    .irq_o             (irq)
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Core model: logs handshakes and pulses done done_delay cycles later
  initial begin
    int  cnt;
    logic hs;
    cnt         = 0;
    core_done_m = 1'b0;
    forever begin
      @(posedge clk);
      hs = core_valid && core_ready;
      if (hs && !rst) hs_q.push_back(core_idx);
      #1;
      core_done_m = 1'b0;
      if (rst) begin
        cnt = 0;
      end else begin
        if (hs) cnt = done_delay;
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) core_done_m = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic reg_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic err);
    @(negedge clk);
    reg_valid = 1'b1;
    reg_write = 1'b1;
    reg_addr  = a;
    reg_wdata = d;
    reg_wstrb = s;
    #1;
    err = reg_error;
    @(posedge clk);
    #1;
    reg_valid = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] a, output logic [31:0] d, output logic err);
    @(negedge clk);
    reg_valid = 1'b1;
    reg_write = 1'b0;
    reg_addr  = a;
    reg_wstrb = 4'h0;
    #1;
    d   = reg_rdata;
    err = reg_error;
    @(posedge clk);
    #1;
    reg_valid = 1'b0;
  endtask

  task automatic wait_not_busy(input string tag);
    logic [31:0] d;
    logic        e;
    logic        ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      reg_rd(A_STAT, d, e);
      if (!d[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_idle_timeout"}, {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_hs(input int n, input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (hs_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_hs_timeout"}, {31'b0, ok}, 32'd1);
  endtask

  task automatic pulse_spur();
    @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
  endtask

  // Directed sequence
  initial begin
    logic [31:0] d;
    logic        e;
    n_chk      = 0;
    n_fail     = 0;
    done_delay = 2;
    rst        = 1'b1;
    reg_valid  = 1'b0;
    reg_write  = 1'b0;
    reg_addr   = '0;
    reg_wdata  = '0;
    reg_wstrb  = '0;
    core_ready = 1'b0;
    spur_done  = 1'b0;

    // Reset state
    #12;
    check("rst_valid", {31'b0, core_valid}, 32'd0);
    check("rst_irq",   {31'b0, irq}, 32'd0);
    check("rst_idx",   {16'b0, core_idx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    reg_rd(A_STAT, d, e); check("rst_status", d, 32'h0);
    reg_rd(A_NUM,  d, e); check("rst_num", d, 32'h0);
    reg_rd(A_CTRL, d, e); check("rst_ctrl", d, 32'h0);
    check("rst_ctrl_err", {31'b0, e}, 32'd0);

    // Three iterations, ready high, done 2 cycles after each handshake
    core_ready = 1'b1;
    done_delay = 2;
    reg_wr(A_NUM, 32'd3, 4'hF, e);  check("t1_num_err", {31'b0, e}, 32'd0);
    reg_wr(A_CTRL, 32'h4, 4'hF, e);
    reg_rd(A_CTRL, d, e);           check("t1_ctrl_rd", d, 32'h4);
    hs_q.delete();
    exp_q = '{16'd0, 16'd1, 16'd2};
    reg_wr(A_CTRL, 32'h5, 4'hF, e); check("t1_start_err", {31'b0, e}, 32'd0);
    wait_not_busy("t1");
    check("t1_hs_count", hs_q.size(), 32'd3);
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
      check($sformatf("t1_idx%0d", i), {16'b0, hs_q[i]}, {16'b0, exp_q[i]});
    reg_rd(A_STAT, d, e);           check("t1_status", d, 32'h0003_0002);
    check("t1_irq_set", {31'b0, irq}, 32'd1);
    reg_wr(A_STAT, 32'h2, 4'hF, e);
    #1;
    check("t1_irq_clr", {31'b0, irq}, 32'd0);
    reg_rd(A_STAT, d, e);           check("t1_status_clr", d, 32'h0003_0000);

    // A spurious done while IDLE leaves progress alone
    pulse_spur();
    reg_rd(A_STAT, d, e);           check("spur_idle", d, 32'h0003_0000);

    // Zero iterations: immediate DONE, no core activity, progress cleared
    hs_q.delete();
    reg_wr(A_NUM, 32'd0, 4'hF, e);
    reg_wr(A_CTRL, 32'h5, 4'hF, e);
    reg_rd(A_STAT, d, e);           check("t2_status", d, 32'h0000_0002);
    check("t2_irq", {31'b0, irq}, 32'd1);
    repeat (4) @(posedge clk);
    check("t2_no_hs", hs_q.size(), 32'd0);
    reg_wr(A_STAT, 32'h2, 4'hF, e);

    // Abort in ISSUE with ready held low
    core_ready = 1'b0;
    hs_q.delete();
    reg_wr(A_NUM, 32'd5, 4'hF, e);
    reg_wr(A_CTRL, 32'h5, 4'hF, e);
    pulse_spur();
    repeat (2) @(posedge clk);
    #1;
    check("t3_valid_hi", {31'b0, core_valid}, 32'd1);
    check("t3_idx0", {16'b0, core_idx}, 32'd0);
    reg_wr(A_CTRL, 32'h6, 4'hF, e);
    check("t3_valid_drop", {31'b0, core_valid}, 32'd0);
    reg_rd(A_STAT, d, e);           check("t3_status", d, 32'h0000_0004);
    check("t3_no_hs", hs_q.size(), 32'd0);
    reg_wr(A_STAT, 32'h4, 4'hF, e);

    // Abort during WAIT of iteration 1: drains, ABORTED only after the done pulse
    core_ready = 1'b1;
    done_delay = 3;
    hs_q.delete();
    reg_wr(A_CTRL, 32'h5, 4'hF, e);
    wait_hs(2, "t4");
    reg_wr(A_CTRL, 32'h6, 4'hF, e);
    reg_rd(A_STAT, d, e);           check("t4_draining", d, 32'h0001_0001);
    wait_not_busy("t4");
    reg_rd(A_STAT, d, e);           check("t4_status", d, 32'h0002_0004);
    check("t4_hs_count", hs_q.size(), 32'd2);
    check("t4_irq", {31'b0, irq}, 32'd1);
    reg_wr(A_STAT, 32'h4, 4'hF, e);

    // Errors: START and NUM_ITER writes while busy, unmapped address, partial strobes
    core_ready = 1'b0;
    reg_wr(A_NUM, 32'd2, 4'hF, e);
    reg_wr(A_CTRL, 32'h5, 4'hF, e);
    reg_wr(A_CTRL, 32'h5, 4'hF, e); check("t5_start_busy_err", {31'b0, e}, 32'd1);
    reg_wr(A_NUM, 32'd7, 4'hF, e);  check("t5_num_busy_err", {31'b0, e}, 32'd1);
    reg_rd(A_NUM, d, e);            check("t5_num_kept", d, 32'd2);
    reg_wr(A_CTRL, 32'h6, 4'hF, e); check("t5_abort_err", {31'b0, e}, 32'd0);
    reg_rd(A_STAT, d, e);           check("t5_aborted", d, 32'h0000_0004);
    reg_wr(A_STAT, 32'h4, 4'hF, e);
    reg_wr(32'h10, 32'h1, 4'hF, e); check("t5_unmapped_wr", {31'b0, e}, 32'd1);
    reg_rd(32'h10, d, e);           check("t5_unmapped_rd_err", {31'b0, e}, 32'd1);
    check("t5_unmapped_rd_data", d, 32'h0);
    reg_wr(A_NUM, 32'd9, 4'h3, e);  check("t5_wstrb_err", {31'b0, e}, 32'd1);
    reg_rd(A_NUM, d, e);            check("t5_wstrb_kept", d, 32'd2);
    reg_rd(A_STAT, d, e);           check("t5_idle", d, 32'h0);

`ifdef LAGD_ISING_CTRL_PERF_EN
    // Busy-cycle counter: 2 iterations x (1 issue + 3 wait) = 8
    core_ready = 1'b1;
    done_delay = 3;
    reg_wr(A_CTRL, 32'h5, 4'hF, e);
    wait_not_busy("t7");
    reg_rd(A_PERF, d, e);           check("t7_perf", d, 32'd8);
    check("t7_perf_rd_err", {31'b0, e}, 32'd0);
    reg_wr(A_PERF, 32'h0, 4'hF, e); check("t7_perf_wr_err", {31'b0, e}, 32'd1);
    reg_wr(A_STAT, 32'h2, 4'hF, e);
`else
    reg_rd(A_PERF, d, e);           check("t7_perf_unmapped_err", {31'b0, e}, 32'd1);
    check("t7_perf_unmapped_data", d, 32'h0);
`endif

    // Asynchronous reset in the middle of WAIT
    core_ready = 1'b1;
    done_delay = 3;
    hs_q.delete();
    reg_wr(A_NUM, 32'd3, 4'hF, e);
    reg_wr(A_CTRL, 32'h5, 4'hF, e);
    wait_hs(2, "t8");
    check("t8_idx_pre", {16'b0, core_idx}, 32'd1);
    rst = 1'b1;
    #1;
    check("t8_valid", {31'b0, core_valid}, 32'd0);
    check("t8_idx", {16'b0, core_idx}, 32'd0);
    check("t8_irq", {31'b0, irq}, 32'd0);
    core_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reg_rd(A_STAT, d, e);           check("t8_status", d, 32'h0);
    reg_rd(A_NUM, d, e);            check("t8_num", d, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
